// File: rtl/axis_cpu_stage1.sv
// axis_cpu_stage1 -- decode/issue stage of the axis_cpu controller.
//
// Sits between stage0 (fetch) and stage2 (writeback). Decodes the incoming
// 8-bit instruction, holds it back while stage2 still has a pending write to
// an operand it needs, and launches the ALU operation when the instruction
// is accepted. The accepted instruction is registered for stage2, together
// with its valid flag and a saturating PC-advance age counter that stage2
// uses for jump correction.
//
// Handshake: a transfer happens on a rising clk edge when the producer's
// valid and the consumer's ready are both high. Valid does not depend on
// ready. Here stage0 -> stage1 uses prev_vld/rdy and stage1 -> stage2 uses
// vld/next_rdy.
//
// Optional feature: define AXIS_CPU_STAGE1_STALL_CNT_EN to add the
// stall_cycles output, a wrapping 32-bit count of cycles in which a valid
// instruction is held back by a hazard.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   instr_in, prev_vld  instruction from stage0 and its valid
//   rdy                 this stage accepts instr_in
//   icount_in, PC_en    age of instr_in; PC advanced this cycle
//   instr_out, vld      registered instruction to stage2 and its valid
//   next_rdy            stage2 ready
//   icount              registered age counter to stage2
//   branch_mispredict   flush from stage2
//   stage2_writes_A/X/imm  pending writes in stage2 (hazard sources)
//   ALU_sel, B_sel, ALU_en  ALU operation, B operand select (1=X), launch strobe
//   stall_cycles        hazard stall counter (optional feature only)

module axis_cpu_stage1 #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int ICOUNT_WIDTH    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              instr_in,
  input  logic                    prev_vld,
  output logic                    rdy,
  input  logic [ICOUNT_WIDTH-1:0] icount_in,
  input  logic                    PC_en,
  output logic [7:0]              instr_out,
  output logic                    vld,
  input  logic                    next_rdy,
  output logic [ICOUNT_WIDTH-1:0] icount,
  input  logic                    branch_mispredict,
  input  logic                    stage2_writes_A,
  input  logic                    stage2_writes_X,
  input  logic                    stage2_writes_imm,
  output logic [3:0]              ALU_sel,
  output logic                    B_sel,
  output logic                    ALU_en
`ifdef AXIS_CPU_STAGE1_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  // axis_cpu_defs encodings used by this stage.
  localparam logic [2:0] CLASS_ALU   = 3'b100;
  localparam logic [2:0] CLASS_JMP   = 3'b101;
  localparam logic [2:0] JMP_JA      = 3'b000;
  localparam logic [3:0] ALU_SEL_CMP = 4'hD;

  // The code address width only keeps the parameter list uniform across
  // the pipeline stages; nothing in this stage addresses code memory.
  logic unused_code_addr;
  assign unused_code_addr = ^CODE_ADDR_WIDTH;

  logic [2:0] op_class;
  logic [2:0] op_type;
  logic       b_x;
  logic       is_alu;
  logic       is_cond_jmp;
  logic       needs_alu;
  logic       hazard;
  logic       accept;

  assign op_class    = instr_in[7:5];
  assign b_x         = instr_in[4];
  assign op_type     = instr_in[2:0];
  assign is_alu      = (op_class == CLASS_ALU);
  assign is_cond_jmp = (op_class == CLASS_JMP) && (op_type != JMP_JA);
  assign needs_alu   = is_alu || is_cond_jmp;

  // Loads, stores and register moves read their operands in stage2, so
  // only ALU-using instructions can collide with a pending stage2 write.
  assign hazard = needs_alu &&
                  (stage2_writes_A ||
                   (b_x && stage2_writes_X) ||
                   (!b_x && stage2_writes_imm));

  // Including rst keeps rdy (and hence ALU_en) low while reset is applied.
  assign rdy    = (!vld || next_rdy) && !hazard && !branch_mispredict && rst;
  assign accept = prev_vld && rdy;

  always_comb begin
    ALU_sel = 4'h0;
    if (is_alu) begin
      ALU_sel = instr_in[3:0];
    end else if (is_cond_jmp) begin
      ALU_sel = ALU_SEL_CMP;
    end
  end

  assign B_sel  = b_x;
  assign ALU_en = accept && needs_alu;

  // Age counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ICOUNT_WIDTH-1:0] sat_inc(
    input logic [ICOUNT_WIDTH-1:0] base,
    input logic                    inc
  );
    logic [ICOUNT_WIDTH:0] sum;
    sum = {1'b0, base} + {{ICOUNT_WIDTH{1'b0}}, inc};
    sat_inc = sum[ICOUNT_WIDTH] ? {ICOUNT_WIDTH{1'b1}} : sum[ICOUNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_out <= 8'h00;
      vld       <= 1'b0;
      icount    <= '0;
    end else if (branch_mispredict) begin
      // Flush: whatever stage2 takes this cycle retires, the rest is dropped.
      vld <= 1'b0;
    end else if (accept) begin
      instr_out <= instr_in;
      vld       <= 1'b1;
      icount    <= sat_inc(icount_in, PC_en);
    end else if (vld && next_rdy) begin
      vld <= 1'b0;
    end else if (vld && !next_rdy) begin
      // Held instruction keeps ageing while stage2 backpressures.
      icount <= sat_inc(icount, PC_en);
    end
  end

`ifdef AXIS_CPU_STAGE1_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
    end else if (prev_vld && hazard && !branch_mispredict) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_cpu_stage1.sv
// Testbench for axis_cpu_stage1: directed vectors with hand-computed
// expectations. Every accepted instruction that is expected to reach stage2
// pushes {instr, icount} into exp_q; a monitor pops and compares on every
// vld && next_rdy transfer. Cycle-level checks (rdy, ALU strobe, ageing,
// flush, reset) are made directly in the stimulus flow.

module tb_axis_cpu_stage1;

  localparam logic [3:0] ALU_SEL_CMP = 4'hD;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] instr_in;
  logic       prev_vld;
  logic       rdy;
  logic [5:0] icount_in;
  logic       PC_en;
  logic [7:0] instr_out;
  logic       vld;
  logic       next_rdy;
  logic [5:0] icount;
  logic       branch_mispredict;
  logic       stage2_writes_A;
  logic       stage2_writes_X;
  logic       stage2_writes_imm;
  logic [3:0] ALU_sel;
  logic       B_sel;
  logic       ALU_en;
`ifdef AXIS_CPU_STAGE1_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  axis_cpu_stage1 #(.CODE_ADDR_WIDTH(10), .ICOUNT_WIDTH(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_in          (instr_in),
    .prev_vld          (prev_vld),
    .rdy               (rdy),
    .icount_in         (icount_in),
    .PC_en             (PC_en),
    .instr_out         (instr_out),
    .vld               (vld),
    .next_rdy          (next_rdy),
    .icount            (icount),
    .branch_mispredict (branch_mispredict),
    .stage2_writes_A   (stage2_writes_A),
    .stage2_writes_X   (stage2_writes_X),
    .stage2_writes_imm (stage2_writes_imm),
    .ALU_sel           (ALU_sel),
    .B_sel             (B_sel),
    .ALU_en            (ALU_en)
`ifdef AXIS_CPU_STAGE1_STALL_CNT_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  // scoreboard
  logic [13:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every stage2 transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && vld && next_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got instr %0h icount %0d, none expected", instr_out, icount);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        check("out_instr", {24'd0, instr_out}, {24'd0, e[13:6]});
        check("out_icount", {26'd0, icount}, {26'd0, e[5:0]});
      end
    end
  end

  // driver tasks
  task automatic drive(input logic pv, input logic [7:0] ins, input logic [5:0] ic,
                       input logic pce, input logic nr, input logic bm,
                       input logic wa, input logic wx, input logic wi);
    prev_vld          = pv;
    instr_in          = ins;
    icount_in         = ic;
    PC_en             = pce;
    next_rdy          = nr;
    branch_mispredict = bm;
    stage2_writes_A   = wa;
    stage2_writes_X   = wx;
    stage2_writes_imm = wi;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stream [4];

  initial begin
    stream[0] = 8'h01; // ld
    stream[1] = 8'h22; // ldx
    stream[2] = 8'h45; // st
    stream[3] = 8'hE7; // misc
    drive(0, 8'h00, 6'd0, 0, 0, 0, 0, 0, 0);

    // reset state
    #2;
    check("rst_vld", {31'd0, vld}, 32'd0);
    check("rst_icount", {26'd0, icount}, 32'd0);
    check("rst_instr", {24'd0, instr_out}, 32'd0);
    check("rst_rdy", {31'd0, rdy}, 32'd0);
    check("rst_alu_en", {31'd0, ALU_en}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // back-to-back non-ALU stream
    for (int k = 0; k < 4; k++) begin
      drive(1, stream[k], 6'(k), 0, 1, 0, 0, 0, 0);
      #3;
      check("b2b_rdy", {31'd0, rdy}, 32'd1);
      check("b2b_alu_en", {31'd0, ALU_en}, 32'd0);
      if (k > 0) check("b2b_vld", {31'd0, vld}, 32'd1);
      exp_q.push_back({stream[k], 6'(k)});
      step();
    end
    drive(0, 8'h00, 6'd0, 0, 1, 0, 0, 0, 0);
    #3;
    check("b2b_last_vld", {31'd0, vld}, 32'd1);
    step();
    #3;
    check("b2b_bubble", {31'd0, vld}, 32'd0);

    // ld never hazards, even with every stage2 write pending
    drive(1, 8'h01, 6'd0, 0, 1, 0, 1, 1, 1);
    #3;
    check("ld_no_hazard_rdy", {31'd0, rdy}, 32'd1);
    check("ld_alu_en", {31'd0, ALU_en}, 32'd0);
    exp_q.push_back({8'h01, 6'd0});
    step();

    // ALU with X operand is unaffected by a pending imm write
    drive(1, 8'h9C, 6'd0, 0, 1, 0, 0, 0, 1);
    #3;
    check("alux_rdy", {31'd0, rdy}, 32'd1);
    check("alux_alu_en", {31'd0, ALU_en}, 32'd1);
    check("alux_sel", {28'd0, ALU_sel}, 32'hC);
    check("alux_bsel", {31'd0, B_sel}, 32'd1);
    exp_q.push_back({8'h9C, 6'd0});
    step();

    // ALU hazard on imm for two cycles, then launch
    for (int c = 0; c < 2; c++) begin
      drive(1, 8'h83, 6'd0, 0, 1, 0, 0, 0, 1);
      #3;
      check("haz_rdy", {31'd0, rdy}, 32'd0);
      check("haz_alu_en", {31'd0, ALU_en}, 32'd0);
      step();
    end
    drive(1, 8'h83, 6'd0, 0, 1, 0, 0, 0, 0);
    #3;
    check("haz_release_rdy", {31'd0, rdy}, 32'd1);
    check("haz_release_alu_en", {31'd0, ALU_en}, 32'd1);
    check("haz_alu_sel", {28'd0, ALU_sel}, 32'h3);
    check("haz_bsel", {31'd0, B_sel}, 32'd0);
    exp_q.push_back({8'h83, 6'd0});
    step();
    drive(0, 8'h83, 6'd0, 0, 1, 0, 0, 0, 0);
    #3;
    check("haz_strobe_once", {31'd0, ALU_en}, 32'd0);
    check("haz_out_vld", {31'd0, vld}, 32'd1);
`ifdef AXIS_CPU_STAGE1_STALL_CNT_EN
    check("stall_cnt", stall_cycles, 32'd2);
`endif
    step();

    // backpressure ageing on a conditional jump
    drive(1, 8'hA1, 6'd5, 1, 1, 0, 0, 0, 0);
    #3;
    check("jmp_alu_en", {31'd0, ALU_en}, 32'd1);
    check("jmp_alu_sel", {28'd0, ALU_sel}, {28'd0, ALU_SEL_CMP});
    exp_q.push_back({8'hA1, 6'd9});
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1, 8'h83, 6'd0, 1, 0, 0, 0, 0, 0);
      #3;
      check("age_icount", {26'd0, icount}, 32'(6 + c));
      check("age_instr", {24'd0, instr_out}, 32'hA1);
      check("age_rdy", {31'd0, rdy}, 32'd0);
      check("age_no_2nd_alu", {31'd0, ALU_en}, 32'd0);
      step();
    end
    drive(0, 8'h00, 6'd0, 0, 1, 0, 0, 0, 0);
    #3;
    check("age_final", {26'd0, icount}, 32'd9);
    step();

    // unconditional jump does not use the ALU
    drive(1, 8'hA0, 6'd0, 0, 1, 0, 1, 1, 1);
    #3;
    check("ja_rdy", {31'd0, rdy}, 32'd1);
    check("ja_alu_en", {31'd0, ALU_en}, 32'd0);
    check("ja_alu_sel", {28'd0, ALU_sel}, 32'd0);
    exp_q.push_back({8'hA0, 6'd0});
    step();

    // saturation
    drive(1, 8'h01, 6'd62, 1, 1, 0, 0, 0, 0);
    #3;
    check("sat_rdy", {31'd0, rdy}, 32'd1);
    exp_q.push_back({8'h01, 6'd63});
    step();
    for (int c = 0; c < 2; c++) begin
      drive(0, 8'h00, 6'd0, 1, 0, 0, 0, 0, 0);
      #3;
      check("sat_icount", {26'd0, icount}, 32'd63);
      step();
    end
    drive(0, 8'h00, 6'd0, 0, 1, 0, 0, 0, 0);
    step();

    // flush with stage2 taking the current output
    drive(1, 8'h22, 6'd1, 0, 1, 0, 0, 0, 0);
    exp_q.push_back({8'h22, 6'd1});
    step();
    drive(1, 8'h83, 6'd0, 0, 1, 1, 0, 0, 0);
    #3;
    check("flush_rdy", {31'd0, rdy}, 32'd0);
    check("flush_alu_en", {31'd0, ALU_en}, 32'd0);
    check("flush_vld_before", {31'd0, vld}, 32'd1);
    step();
    drive(1, 8'h45, 6'd2, 0, 1, 0, 0, 0, 0);
    #3;
    check("flush_vld_after", {31'd0, vld}, 32'd0);
    check("flush_next_rdy", {31'd0, rdy}, 32'd1);
    exp_q.push_back({8'h45, 6'd2});
    step();
    drive(0, 8'h00, 6'd0, 0, 1, 0, 0, 0, 0);
    #3;
    check("flush_next_out", {24'd0, instr_out}, 32'h45);
    step();

    // async reset in the middle of a stall
    drive(1, 8'h83, 6'd3, 0, 1, 0, 0, 0, 0);
    #3;
    check("pre_rst_alu_en", {31'd0, ALU_en}, 32'd1);
    step();
    drive(1, 8'h84, 6'd0, 0, 0, 0, 1, 0, 0);
    #2;
    check("pre_rst_vld", {31'd0, vld}, 32'd1);
    check("pre_rst_icount", {26'd0, icount}, 32'd3);
    rst = 1'b0;
    #1;
    check("arst_vld", {31'd0, vld}, 32'd0);
    check("arst_icount", {26'd0, icount}, 32'd0);
    check("arst_instr", {24'd0, instr_out}, 32'd0);
    check("arst_rdy", {31'd0, rdy}, 32'd0);
    check("arst_alu_en", {31'd0, ALU_en}, 32'd0);
`ifdef AXIS_CPU_STAGE1_STALL_CNT_EN
    check("arst_stall_cnt", stall_cycles, 32'd0);
`endif
    step();
    drive(0, 8'h00, 6'd0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();

    // final report
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
